// File: rtl/fsm_q6_pkg.sv
// Shared types and helpers for the six-state A-F sequencing machine.
package fsm_q6_pkg;

  // State codes as seen on y[3:1]
  typedef enum logic [2:0] {
    S_A = 3'b000,
    S_B = 3'b001,
    S_C = 3'b010,
    S_D = 3'b011,
    S_E = 3'b100,
    S_F = 3'b101
  } state_t;

  // Any code with both upper bits set (110/111) is unused
  localparam logic [2:0] ST_ILLEGAL_MASK = 3'b110;

  // True for the output region {E,F}
  function automatic logic is_zone(input state_t s);
    return (s == S_E) || (s == S_F);
  endfunction

  // True for the six assigned codes 000..101
  function automatic logic is_legal(input logic [2:0] code);
    return (code & ST_ILLEGAL_MASK) != ST_ILLEGAL_MASK;
  endfunction

endpackage

// File: rtl/fsm_q6_seq_ctrl_if.sv
// Host-side bundle for the sequencing controller: stimulus in, state and status out.
interface fsm_q6_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             w_valid;
  logic             w;
  logic             load;
  logic [2:0]       load_state;
  logic             clr_cnt;
  logic [3:1]       y;
  logic             z;
  logic             stepped;
  logic [CNT_W-1:0] z_count;
  logic             load_err;

  modport master (
    output w_valid, w, load, load_state, clr_cnt,
    input  y, z, stepped, z_count, load_err
  );

  modport slave (
    input  w_valid, w, load, load_state, clr_cnt,
    output y, z, stepped, z_count, load_err
  );
endinterface

// File: rtl/fsm_q6_next.sv
// Combinational next-state function of the A-F machine; next_y[2] is the Y2 bit.
module fsm_q6_next
  import fsm_q6_pkg::*;
(
  input  logic [3:1] y,
  input  logic       w,
  output logic [3:1] next_y,
  output logic       illegal
);

  // Table lookup; unused codes fall back to A and raise illegal
  always_comb begin
    next_y  = S_A;
    illegal = 1'b0;
    case (state_t'(y))
      S_A:     next_y = w ? S_A : S_B;
      S_B:     next_y = w ? S_D : S_C;
      S_C:     next_y = w ? S_D : S_E;
      S_D:     next_y = w ? S_A : S_F;
      S_E:     next_y = w ? S_D : S_E;
      S_F:     next_y = w ? S_D : S_C;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fsm_q6_seq_ctrl.sv
// Sequencing controller for the A-F machine: state register, load/step priority,
// step pulse, saturating {E,F} entry counter and sticky illegal-load flag.
//
//   state | meaning
//   A 000 | idle / restart
//   B 001 | one w=0 seen from A
//   C 010 | second leg
//   D 011 | branch point back to A or into F
//   E 100 | output region, holds on w=0
//   F 101 | output region, leaves on any w
module fsm_q6_seq_ctrl
  import fsm_q6_pkg::*;
#(
  parameter int         CNT_W       = 8,
  parameter logic [2:0] RESET_STATE = 3'b000
)(
  input  logic             clk,
  input  logic             reset,
  fsm_q6_seq_ctrl_if.slave bus
);

  state_t           y_q;
  logic             stepped_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_err_q;

  logic [3:1]       nx_y;
  logic             nx_illegal;
  logic             zone_entry;

  fsm_q6_next u_next (
    .y       (y_q),
    .w       (bus.w),
    .next_y  (nx_y),
    .illegal (nx_illegal)
  );

  // A step counts only when it crosses from {A..D} into {E,F}
  always_comb begin
    zone_entry = !is_zone(y_q) && is_zone(state_t'(nx_y));
  end

  // Priority: reset > illegal-state recovery > load > step > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q        <= state_t'(RESET_STATE);
      stepped_q  <= 1'b0;
      cnt_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      stepped_q <= 1'b0;
      if (nx_illegal) begin
        y_q <= S_A;
      end else if (bus.load) begin
        if (is_legal(bus.load_state)) begin
          y_q <= state_t'(bus.load_state);
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (bus.w_valid) begin
        y_q       <= state_t'(nx_y);
        stepped_q <= 1'b1;
        if (zone_entry && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      // Clear overrides any increment taken in the same cycle
      if (bus.clr_cnt) begin
        cnt_q <= '0;
      end
    end
  end

  assign bus.y        = y_q;
  assign bus.z        = is_zone(y_q);
  assign bus.stepped  = stepped_q;
  assign bus.z_count  = cnt_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_fsm_q6_seq_ctrl.sv
// Directed bench for fsm_q6_seq_ctrl: main instance (CNT_W=8) and a narrow
// instance (CNT_W=2) for counter saturation.
module tb_fsm_q6_seq_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  fsm_q6_seq_ctrl_if #(.CNT_W(8)) bus8 ();
  fsm_q6_seq_ctrl_if #(.CNT_W(2)) bus2 ();

  fsm_q6_seq_ctrl #(.CNT_W(8), .RESET_STATE(3'b000)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  fsm_q6_seq_ctrl #(.CNT_W(2), .RESET_STATE(3'b000)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and samples sit 1 time unit past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    bus8.w_valid = 1'b0; bus8.w = 1'b0; bus8.load = 1'b0;
    bus8.load_state = 3'b000; bus8.clr_cnt = 1'b0;
  endtask

  task automatic step8(input logic wv);
    bus8.w_valid = 1'b1; bus8.w = wv;
    tick();
    bus8.w_valid = 1'b0;
  endtask

  task automatic load8(input logic [2:0] s);
    bus8.load = 1'b1; bus8.load_state = s;
    tick();
    bus8.load = 1'b0;
  endtask

  task automatic step2(input logic wv);
    bus2.w_valid = 1'b1; bus2.w = wv;
    tick();
    bus2.w_valid = 1'b0;
  endtask

  logic [2:0]  exp_next [12];
  logic [11:0] y2_exp;

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_next = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b100, 3'b011,
                 3'b101, 3'b000, 3'b100, 3'b011, 3'b010, 3'b011};
    y2_exp = 12'b111000101100;

    idle8();
    bus2.w_valid = 1'b0; bus2.w = 1'b0; bus2.load = 1'b0;
    bus2.load_state = 3'b000; bus2.clr_cnt = 1'b0;

    reset = 1'b1;
    #1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_y", bus8.y, 3'b000);
    chk("rst_z", bus8.z, 1'b0);
    chk("rst_stepped", bus8.stepped, 1'b0);
    chk("rst_cnt", bus8.z_count, 8'd0);
    chk("rst_err", bus8.load_err, 1'b0);

    // Narrow counter saturates at 3 after four A->B->C->E->D->A loops
    for (int k = 0; k < 4; k++) begin
      step2(1'b0); step2(1'b0); step2(1'b0);
      chk("sat_at_e", bus2.y, 3'b100);
      step2(1'b1); step2(1'b1);
      chk("sat_back_a", bus2.y, 3'b000);
      chk("sat_cnt", bus2.z_count, (k < 3) ? k + 1 : 3);
    end

    // A -> B -> C -> E
    step8(1'b0);
    chk("s1_y", bus8.y, 3'b001);
    chk("s1_stepped", bus8.stepped, 1'b1);
    step8(1'b0);
    chk("s2_y", bus8.y, 3'b010);
    chk("s2_stepped", bus8.stepped, 1'b1);
    step8(1'b0);
    chk("s3_y", bus8.y, 3'b100);
    chk("s3_z", bus8.z, 1'b1);
    chk("s3_cnt", bus8.z_count, 8'd1);
    chk("s3_stepped", bus8.stepped, 1'b1);

    // E -E-> E -> D -> F -> D -> A
    step8(1'b0);
    chk("ee_y", bus8.y, 3'b100);
    chk("ee_stepped", bus8.stepped, 1'b1);
    chk("ee_cnt", bus8.z_count, 8'd1);
    step8(1'b1);
    chk("ed_y", bus8.y, 3'b011);
    chk("ed_z", bus8.z, 1'b0);
    step8(1'b0);
    chk("df_y", bus8.y, 3'b101);
    chk("df_cnt", bus8.z_count, 8'd2);
    step8(1'b1);
    chk("fd_y", bus8.y, 3'b011);
    step8(1'b1);
    chk("da_y", bus8.y, 3'b000);
    chk("da_z", bus8.z, 1'b0);
    chk("da_cnt", bus8.z_count, 8'd2);

    // Hold with w toggling
    for (int k = 0; k < 5; k++) begin
      bus8.w = k[0];
      tick();
      chk("hold_y", bus8.y, 3'b000);
      chk("hold_stepped", bus8.stepped, 1'b0);
    end
    chk("hold_cnt", bus8.z_count, 8'd2);

    // Load beats a same-cycle step, landing in F without counting
    bus8.load = 1'b1; bus8.load_state = 3'b101;
    bus8.w_valid = 1'b1; bus8.w = 1'b0;
    tick();
    idle8();
    chk("ld_y", bus8.y, 3'b101);
    chk("ld_stepped", bus8.stepped, 1'b0);
    chk("ld_cnt", bus8.z_count, 8'd2);

    // Illegal load holds state and sets a flag that clr_cnt leaves alone
    load8(3'b111);
    chk("ill_y", bus8.y, 3'b101);
    chk("ill_err", bus8.load_err, 1'b1);
    bus8.clr_cnt = 1'b1;
    tick();
    bus8.clr_cnt = 1'b0;
    chk("clr_cnt", bus8.z_count, 8'd0);
    chk("clr_err", bus8.load_err, 1'b1);
    load8(3'b110);
    chk("ill6_y", bus8.y, 3'b101);

    // Clear wins over a coincident D->F increment
    load8(3'b011);
    step8(1'b0);
    chk("df1_cnt", bus8.z_count, 8'd1);
    load8(3'b011);
    bus8.clr_cnt = 1'b1;
    step8(1'b0);
    bus8.clr_cnt = 1'b0;
    chk("clrinc_y", bus8.y, 3'b101);
    chk("clrinc_cnt", bus8.z_count, 8'd0);

    // Sweep every legal {y,w}
    for (int i = 0; i < 12; i++) begin
      load8(3'(i >> 1));
      step8(i[0]);
      chk($sformatf("sweep_%0d", i), bus8.y, exp_next[i]);
      chk($sformatf("y2_%0d", i), bus8.y[2], y2_exp[i]);
    end
    chk("sweep_cnt", bus8.z_count, 8'd2);

    // Reset while a step is pending
    bus8.w_valid = 1'b1; bus8.w = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle8();
    chk("mid_rst_y", bus8.y, 3'b000);
    chk("mid_rst_cnt", bus8.z_count, 8'd0);
    chk("mid_rst_err", bus8.load_err, 1'b0);
    chk("mid_rst_stepped", bus8.stepped, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
